// File: rtl/wb_port_writer.sv
// Register-file write-back port: merges never-stalled pipeline results with FIFO-buffered
// long-latency results and kills stale queued writes. Optional macro: WB_AUX_BYPASS_EN.
module wb_port_writer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_waddr,
  input  logic [31:0]              pipe_wdata,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [4:0]               aux_waddr,
  input  logic [31:0]              aux_wdata,
  output logic                     we,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  input  logic [4:0]               chk_addr1,
  input  logic [4:0]               chk_addr2,
  output logic                     chk_hit1,
  output logic                     chk_hit2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]        live;
  logic [DEPTH-1:0][4:0]   addr_q;
  logic [DEPTH-1:0][31:0]  data_q;
  logic [PW-1:0]           head, tail;
  logic [CW-1:0]           cnt;

  logic pipe_acc, push, enq, pop, bypass;

  assign pipe_acc  = pipe_we && (pipe_waddr != 5'd0);
  assign aux_ready = rst && (cnt < CW'(DEPTH));
  // Transfers to $0 complete the handshake but never occupy an entry.
  assign push      = aux_valid && aux_ready && (aux_waddr != 5'd0);
  assign pop       = !pipe_acc && (cnt != '0);
`ifdef WB_AUX_BYPASS_EN
  assign bypass    = push && (cnt == '0) && !pipe_acc;
`else
  assign bypass    = 1'b0;
`endif
  assign enq       = push && !bypass;
  assign count     = cnt;

  // Entry state: enqueue wins over kill so a same-cycle aux write to R survives.
  // Popped entries drop live, so live alone marks an occupied, unkilled entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && tail == PW'(i)) begin
          live[i]   <= 1'b1;
          addr_q[i] <= aux_waddr;
          data_q[i] <= aux_wdata;
        end else if ((pop && head == PW'(i)) ||
                     (pipe_acc && addr_q[i] == pipe_waddr)) begin
          live[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      case ({enq, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Output register; killed pops and idle cycles hold the last address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (pipe_acc) begin
      we    <= 1'b1;
      waddr <= pipe_waddr;
      wdata <= pipe_wdata;
    end else if (pop) begin
      we <= live[head];
      if (live[head]) begin
        waddr <= addr_q[head];
        wdata <= data_q[head];
      end
    end else if (bypass) begin
      we    <= 1'b1;
      waddr <= aux_waddr;
      wdata <= aux_wdata;
    end else begin
      we <= 1'b0;
    end
  end

  always_comb begin
    chk_hit1 = 1'b0;
    chk_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && addr_q[i] == chk_addr1) chk_hit1 = 1'b1;
      if (live[i] && addr_q[i] == chk_addr2) chk_hit2 = 1'b1;
    end
    if (chk_addr1 == 5'd0) chk_hit1 = 1'b0;
    if (chk_addr2 == 5'd0) chk_hit2 = 1'b0;
  end
endmodule

// File: tb/tb_wb_port_writer.sv
// Scoreboard bench for wb_port_writer: expected register-file writes are queued by the
// stimulus and retired by a monitor that watches the write port.
module tb_wb_port_writer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_waddr = '0;
  logic [31:0] aux_wdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  chk_addr1 = '0, chk_addr2 = '0;
  logic        chk_hit1, chk_hit2;
  logic [$clog2(DEPTH):0] count;

  wb_port_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] rf [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0; aux_valid = 1'b0;
  endtask

  // Monitor: every DUT write must be the next expected write, in order.
  always @(negedge clk) begin
    if (rst && we) begin
      rf[waddr] = wdata;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got $%0d=0x%0h expected no write", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, waddr}, {27'd0, e.a});
        check("wr_data", wdata, e.d);
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;

    // reset state
    #3;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", {31'd0, aux_ready}, 32'd0);
    #4 rst = 1'b1;
    tick();
    check("idle_ready", {31'd0, aux_ready}, 32'd1);
    check("idle_count", 32'(count), 32'd0);
    check("idle_we", {31'd0, we}, 32'd0);

    // pipe write $5 <- 0x1234, visible the next cycle
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    tick();
    check("pipe_lat_we", {31'd0, we}, 32'd1);
    // pipe write to $0 is dropped
    pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
    tick();
    check("pipe_r0_we", {31'd0, we}, 32'd0);
    idle();
    tick();

    // fill the FIFO while the pipe keeps the port busy
    for (int i = 0; i < DEPTH; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'(1 + i); pipe_wdata = 32'h100 + i;
      aux_valid = 1'b1; aux_waddr = 5'(10 + i); aux_wdata = 32'hA0 + i;
      exp_q.push_back({5'(1 + i), 32'h100 + i});
      tick();
    end
    idle();
    check("full_count", 32'(count), 32'd4);
    check("full_ready", {31'd0, aux_ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({5'(10 + i), 32'hA0 + i});
    tick();
    check("pop1_ready", {31'd0, aux_ready}, 32'd1);
    check("pop1_count", 32'(count), 32'd3);
    repeat (3) tick();
    check("drain_count", 32'(count), 32'd0);
    tick();

    // WAW kill: queued $7 is superseded by a later pipe write
    chk_addr1 = 5'd7;
    pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1;
    aux_valid = 1'b1; aux_waddr = 5'd7; aux_wdata = 32'hAAAA;
    exp_q.push_back({5'd1, 32'h1});
    tick();
    aux_valid = 1'b0;
    check("waw_hit_before", {31'd0, chk_hit1}, 32'd1);
    pipe_waddr = 5'd7; pipe_wdata = 32'hBBBB;
    exp_q.push_back({5'd7, 32'hBBBB});
    tick();
    idle();
    check("waw_hit_after", {31'd0, chk_hit1}, 32'd0);
    check("waw_count", 32'(count), 32'd1);
    tick();
    check("waw_killed_we", {31'd0, we}, 32'd0);
    check("waw_drain", 32'(count), 32'd0);
    tick();

    // same-cycle pipe and aux to $3: aux is newer and stays live
    chk_addr2 = 5'd3;
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h1;
    aux_valid = 1'b1; aux_waddr = 5'd3; aux_wdata = 32'h2;
    exp_q.push_back({5'd3, 32'h1});
    exp_q.push_back({5'd3, 32'h2});
    tick();
    idle();
    check("same_hit", {31'd0, chk_hit2}, 32'd1);
    repeat (2) tick();
    check("same_hit_gone", {31'd0, chk_hit2}, 32'd0);

    // aux to $9 with idle pipe and empty FIFO
    aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h55;
    exp_q.push_back({5'd9, 32'h55});
    tick();
    idle();
`ifdef WB_AUX_BYPASS_EN
    check("byp_we_n1", {31'd0, we}, 32'd1);
    check("byp_count", 32'(count), 32'd0);
`else
    check("byp_we_n1", {31'd0, we}, 32'd0);
    check("byp_count", 32'(count), 32'd1);
    tick();
    check("byp_we_n2", {31'd0, we}, 32'd1);
`endif
    repeat (2) tick();

    // asynchronous reset mid-burst
    pipe_we = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'h20;
    aux_valid = 1'b1; aux_waddr = 5'd21; aux_wdata = 32'h21;
    exp_q.push_back({5'd20, 32'h20});
    tick();
    pipe_waddr = 5'd22; pipe_wdata = 32'h22;
    aux_waddr = 5'd23; aux_wdata = 32'h23;
    tick();
    idle();
    check("burst_count", 32'(count), 32'd2);
    #1 rst = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_we", {31'd0, we}, 32'd0);
    check("arst_ready", {31'd0, aux_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_ready", {31'd0, aux_ready}, 32'd1);

    check("rf_r7_final", rf[7], 32'hBBBB);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_port_writer.md
# wb_port_writer

Write-back port driver for the 32×32 general register file. It merges two result sources onto the register file's single write port (`we`/`waddr`/`wdata`): in-order pipeline results, which are never stalled, and results from long-latency units (divider, load miss), which are buffered in a small FIFO. It also exposes a pending-write lookup so decode can stall on registers with writes still queued. It sits between the MEM/WB stage and the register file.

## Interface
- `DEPTH`, 4, aux FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `pipe_we`  in  1  pipeline write-back valid; always accepted.
- `pipe_waddr`  in  5  pipeline destination register.
- `pipe_wdata`  in  32  pipeline result.
- `aux_valid`  in  1  long-latency result offered.
- `aux_ready`  out  1  FIFO can accept; transfer when `aux_valid && aux_ready`.
- `aux_waddr`  in  5  aux destination register.
- `aux_wdata`  in  32  aux result.
- `we`  out  1  register file write enable (registered).
- `waddr`  out  5  register file write address (registered).
- `wdata`  out  32  register file write data (registered).
- `chk_addr1`, `chk_addr2`  in  5 each  decode source registers to check.
- `chk_hit1`, `chk_hit2`  out  1 each  a live queued write targets that register (combinational).
- `count`  out  $clog2(DEPTH)+1  occupied FIFO entries, including killed entries.

## Operation
- FIFO entry = {live, addr[4:0], data[31:0]}; circular head/tail pointers wrap modulo DEPTH; `count` is tracked separately so full and empty are unambiguous.
- Enqueue: an aux transfer with `aux_waddr`≠0 writes the entry at tail with live=1. An aux transfer to $0 is accepted (handshake completes) and discarded.
- Output selection each cycle, in priority order:
  1. `pipe_we` with `pipe_waddr`≠0 → output register loads the pipe write; the FIFO does not pop.
  2. Otherwise, FIFO non-empty → pop the head. If the head is live, load it (`we`=1). If it is killed, `we`=0.
  3. Otherwise → `we`=0. `waddr`/`wdata` hold their previous values.
- `pipe_we` with `pipe_waddr`=0 counts as no pipe write; the FIFO may pop in that cycle.
- WAW kill: when a pipe write to R is accepted, every FIFO entry with addr=R has live cleared in the same edge. An older queued value must never overwrite a newer pipeline value. An aux entry enqueued in that same cycle with addr=R is not killed, because it is newer.
- `aux_ready` = (`count` < DEPTH) while `rst`=1; it is 0 while in reset. Simultaneous pop and push when full is not allowed (ready is low when full).
- `chk_hitN` = OR over occupied, live entries of (addr==`chk_addrN`). It is 0 when `chk_addrN`=0. The in-flight output register is not included; the register file's write-through forwarding covers it.
- Starvation: continuous pipe writes starve the FIFO. This is accepted; the aux producer sees `aux_ready`=0 and holds.

## Timing
- Reset (asynchronous assert): `we`=0, `waddr`=0, `wdata`=0, `count`=0, all live bits cleared, pointers=0. Reset mid-operation discards all queued entries.
- Pipe write in cycle N → `we`=1 with the data in cycle N+1; the register file commits at the end of N+1.
- Aux write with FIFO path: accepted in N, earliest pop in N+1, `we`=1 in N+2.
- `count` updates on the edge: +1 on push, −1 on pop, unchanged on push+pop.

## Configuration
- `WB_AUX_BYPASS_EN` defined: if in cycle N the FIFO is empty, no pipe write is accepted, and an aux transfer to a nonzero register occurs, the aux result loads the output register directly (`we`=1 in N+1) and is not enqueued; `count` stays 0.
- Not defined: all aux results go through the FIFO (minimum 2-cycle latency).

## Test plan
- Reset then idle: `we`=0, `count`=0, `aux_ready`=1; asserting `rst`=0 mid-burst clears `count` to 0 and `we` to 0 asynchronously.
- Pipe write $5←0x1234 in cycle N → `we`=1, `waddr`=5, `wdata`=0x1234 at N+1. Pipe write to $0 → `we`=0.
- FIFO fill: DEPTH aux pushes with continuous pipe writes → `count`=4, `aux_ready`=0. Pipe stops → 4 pops in order over 4 cycles; `aux_ready` returns to 1 after the first pop.
- WAW kill: queue aux $7←0xAAAA, then pipe $7←0xBBBB → `chk_hit`(7) drops to 0; the killed pop gives `we`=0; the final value of $7 is 0xBBBB.
- Same-cycle pipe $3←1 and aux $3←2 → the aux entry stays live; write order is 1 then 2.
- Bypass: with FIFO empty and no pipe write, aux $9←0x55 at N → `we`=1 at N+1 if `WB_AUX_BYPASS_EN` is defined, otherwise at N+2.
